servant_wb_arbiter_rr: RTL
==========================

Name: servant_wb_arbiter_rr

Overview:
- Parametrised N-master to 1-slave Wishbone (classic, cyc-only, no stb) arbiter. Successor to the fixed two-master priority arbiter that places CPU ibus/dbus and the debug module in front of the RAM.
- Adds round-robin fairness, a registered grant and a per-transaction watchdog that terminates hung slave cycles with an error pulse.
- Sits between the CPU buses, the debug module system-bus master, optional DMA masters and a shared slave (RAM or the peripheral mux).

Parameters:
- NUM_MASTERS, 3: number of masters (2..8); index 0 is the highest-priority seed after reset.
- AW, 32: address width.
- DW, 32: data width; sel width is DW/8.
- TIMEOUT, 255: watchdog cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_m_adr  in  NUM_MASTERS*AW  master addresses; master k occupies [k*AW +: AW]
- i_m_dat  in  NUM_MASTERS*DW  master write data
- i_m_sel  in  NUM_MASTERS*DW/8  master byte selects
- i_m_we  in  NUM_MASTERS  master write enables
- i_m_cyc  in  NUM_MASTERS  master cycle requests
- o_m_rdt  out  DW  read data, shared by all masters
- o_m_ack  out  NUM_MASTERS  per-master ack
- o_m_err  out  NUM_MASTERS  per-master watchdog-abort pulse
- o_s_adr  out  AW  slave address
- o_s_dat  out  DW  slave write data
- o_s_sel  out  DW/8  slave byte selects
- o_s_we  out  1  slave write enable
- o_s_cyc  out  1  slave cycle
- i_s_rdt  in  DW  slave read data
- i_s_ack  in  1  slave ack (single-cycle pulse)
- o_grant  out  NUM_MASTERS  one-hot current owner; all zero in IDLE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; o_grant = 0; o_s_cyc = 0; o_m_ack = 0; o_m_err = 0.
  - last-granted pointer = NUM_MASTERS-1, so master 0 wins the first tie.
  - watchdog count = 0.
- State IDLE:
  - o_s_cyc = 0.
  - If any i_m_cyc is set, select the first requester scanning upward from (last+1) mod NUM_MASTERS.
  - Register the winner into o_grant, set last = winner, go to BUSY.
  - Arbitration latency is 1 cycle; the slave sees cyc no earlier than the cycle after the request.
- State BUSY:
  - o_s_adr, o_s_dat, o_s_sel and o_s_we are combinationally muxed from the granted master.
  - o_s_cyc = i_m_cyc[g].
  - o_m_ack[g] = i_s_ack; all other acks are 0.
  - o_m_rdt = i_s_rdt unconditionally.
  - Watchdog increments each cycle.
- Exits from BUSY (all go to IDLE next cycle; grant cleared, watchdog cleared):
  - i_s_ack = 1.
  - i_m_cyc[g] = 0 (master abort); no ack or err is produced.
  - TIMEOUT != 0, watchdog == TIMEOUT-1 and no ack in that cycle: o_m_err[g] pulses 1 cycle (registered, visible in the first IDLE cycle) and o_s_cyc drops.
- Simultaneous events in the same cycle:
  - ack together with the timeout condition: ack wins, no err.
  - ack together with cyc drop: ack is delivered.
- Back-to-back requests: a master holding cyc after its ack is re-arbitrated in IDLE. Every transaction costs at least 1 IDLE cycle, and another pending master gets the next grant.
- Requests from non-granted masters are ignored until IDLE; they are never acked.
- Async reset mid-transaction drops o_s_cyc and all acks immediately.
- Width rules:
  - Watchdog counter width is clog2(TIMEOUT+1).
  - Pointer wrap is mod NUM_MASTERS; non-power-of-two counts must wrap correctly (e.g. 2 -> 0 for 3 masters).

Test Plan:
- Reset then master1 cyc=1 with adr=0x100, slave acks after 2 cycles with rdt=0xDEADBEEF -> o_grant=3'b010 one cycle after request; o_s_adr=0x100; o_m_ack[1] pulses once with o_m_rdt=0xDEADBEEF; o_grant=0 next cycle.
- All 3 masters hold cyc continuously, slave acks immediately -> grants sequence 0,1,2,0,1,2; each grant is separated by one IDLE cycle; no master is starved.
- Master2 write (we=1, dat=0x12345678, sel=4'b0011) while master0 is idle -> slave sees we=1, dat=0x12345678, sel=0011; only o_m_ack[2] asserts.
- TIMEOUT=8, master0 requests, slave never acks -> o_s_cyc high for exactly 8 cycles; o_m_err[0] pulses once; state IDLE; master1 then served normally.
- Master1 drops cyc 2 cycles into BUSY -> o_s_cyc falls the same cycle; no ack or err; IDLE next cycle; last pointer = 1, so master2 wins a 1/2 tie.
- Assert i_rstn=0 during BUSY with slave ack pending -> o_s_cyc, o_grant and o_m_ack are 0 immediately; after release master0 wins a simultaneous 0/1/2 request.

Source files
------------

// File: rtl/servant_wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// servant_wb_arbiter_rr
// N-master to 1-slave Wishbone (classic, cyc-only) round-robin arbiter with a
// registered grant and a per-transaction watchdog that aborts hung slave cycles.
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_m_adr/dat/sel/we/cyc packed master request buses, master k at [k*W +: W]
//   o_m_rdt                shared read data (slave read data passed through)
//   o_m_ack                per-master ack, only the granted master sees i_s_ack
//   o_m_err                per-master one-cycle watchdog-abort pulse
//   o_s_adr/dat/sel/we/cyc slave request, muxed from the granted master
//   i_s_rdt, i_s_ack       slave response
//   o_grant                one-hot current owner, zero while idle
// ---------------------------------------------------------------------------
module servant_wb_arbiter_rr #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [NUM_MASTERS*AW-1:0]   i_m_adr,
    input  logic [NUM_MASTERS*DW-1:0]   i_m_dat,
    input  logic [NUM_MASTERS*DW/8-1:0] i_m_sel,
    input  logic [NUM_MASTERS-1:0]      i_m_we,
    input  logic [NUM_MASTERS-1:0]      i_m_cyc,
    output logic [DW-1:0]               o_m_rdt,
    output logic [NUM_MASTERS-1:0]      o_m_ack,
    output logic [NUM_MASTERS-1:0]      o_m_err,
    output logic [AW-1:0]               o_s_adr,
    output logic [DW-1:0]               o_s_dat,
    output logic [DW/8-1:0]             o_s_sel,
    output logic                        o_s_we,
    output logic                        o_s_cyc,
    input  logic [DW-1:0]               i_s_rdt,
    input  logic                        i_s_ack,
    output logic [NUM_MASTERS-1:0]      o_grant
);

    localparam int unsigned PW  = $clog2(NUM_MASTERS);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned SW  = DW / 8;
    // Keep at least one bit so a disabled watchdog still elaborates.
    localparam int unsigned WdW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] err_q, err_d;
    logic [PW-1:0]          last_q, last_d;
    logic [WdW-1:0]         wdog_q, wdog_d;
    logic [PW-1:0]          winner;
    logic                   winner_vld;
    logic [CW-1:0]          cand;
    logic                   cyc_g;
    logic                   busy;
    logic                   timeout_hit;

    assign busy = (state_q == StBusy);

    // Round-robin scan upward from last+1. last < N and offset <= N, so a
    // single conditional subtract wraps correctly for non-power-of-two counts.
    always_comb begin
        winner     = last_q;
        winner_vld = 1'b0;
        cand       = '0;
        for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
            cand = {1'b0, last_q} + CW'(i);
            if (cand >= CW'(NUM_MASTERS)) begin
                cand = cand - CW'(NUM_MASTERS);
            end
            if (!winner_vld && i_m_cyc[cand[PW-1:0]]) begin
                winner     = cand[PW-1:0];
                winner_vld = 1'b1;
            end
        end
    end

    // In BUSY last_q holds the granted index, so it drives the request mux.
    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        cyc_g   = 1'b0;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            if (last_q == PW'(k)) begin
                o_s_adr = i_m_adr[k*AW +: AW];
                o_s_dat = i_m_dat[k*DW +: DW];
                o_s_sel = i_m_sel[k*SW +: SW];
                o_s_we  = i_m_we[k];
                cyc_g   = i_m_cyc[k];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WdW'(TIMEOUT - 1));

    assign o_s_cyc = busy & cyc_g;
    assign o_m_ack = (busy && i_s_ack) ? grant_q : '0;
    assign o_m_rdt = i_s_rdt;
    assign o_grant = grant_q;
    assign o_m_err = err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        err_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (winner_vld) begin
                    state_d         = StBusy;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    last_d          = winner;
                    wdog_d          = '0;
                end
            end
            StBusy: begin
                if (TIMEOUT != 0) begin
                    wdog_d = wdog_q + WdW'(1);
                end
                // Ack has priority over both abort and timeout; a master abort
                // never raises err.
                if (i_s_ack || !cyc_g || timeout_hit) begin
                    state_d = StIdle;
                    grant_d = '0;
                    wdog_d  = '0;
                    if (!i_s_ack && cyc_g && timeout_hit) begin
                        err_d = grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            grant_q <= '0;
            err_q   <= '0;
            last_q  <= PW'(NUM_MASTERS - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule
